word_scrambler: RTL and testbench
=================================

// Module: word_scrambler
// PURPOSE
//  Letter-buffer datapath paired with the game controller. Loads the target word
//  and scrambles it with a free-running LFSR on scramPls. Swaps two letter
//  positions per flipPls. Pulses isCorrect when the working word matches the target.
//  Sits between the word source (wordIn) and the controller (scramPls/flipPls/indOut*/lettNum in, isCorrect out).
// PARAMETERS
//  MAXLEN      8      letter slots held (index width 3 bits)
//  LW          5      bits per letter code (0 = blank)
//  SCRAM_SWAPS 16     random swaps performed per scramble
//  LFSR_SEED   8'hA5  LFSR reset value; must be nonzero
// PORTS
//  clk        in   1           system clock, all state on posedge
//  rst        in   1           synchronous, active-low reset
//  lettNum    in   2           word length select; len = lettNum+4 (4..7)
//  wordIn     in   MAXLEN*LW   target word; letter k at [k*LW +: LW]
//  scramPls   in   1           load wordIn and scramble
//  flipPls    in   1           swap letters at indIn1/indIn2
//  indIn1     in   3           first swap index
//  indIn2     in   3           second swap index
//  isCorrect  out  1           one-cycle pulse: working word == target
//  busy       out  1           high while scrambling; flips/loads ignored
//  wordOut    out  MAXLEN*LW   working (scrambled) word for display
//  swapCount  out  7           valid player flips since last load; saturates at 127
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; outputs isCorrect, busy, swapCount = 0.
//   wordOut and target = 0. LFSR = LFSR_SEED. Overrides everything, including mid-scramble.
//  LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Steps every cycle in every state.
//   If it ever reads 0, it reloads LFSR_SEED.
//  States: IDLE, SCRAMBLE, FIXUP, PLAY, COMPARE, SOLVED.
//  scramPls is accepted in IDLE, PLAY and SOLVED, and ignored elsewhere. On accept:
//   - latch len = lettNum+4.
//   - target and working word <= wordIn, with slots >= len forced to 0.
//   - swapCount <= 0, cnt <= 0, busy <= 1, go to SCRAMBLE.
//  scramPls and flipPls in the same cycle: scramPls wins; the flip is discarded.
//  SCRAMBLE (exactly SCRAM_SWAPS cycles):
//   - i = lfsr[2:0], j = lfsr[5:3]; each reduced by subtracting len once if >= len.
//   - swap working[i] and working[j] (i==j leaves the word unchanged); cnt++.
//   - at cnt == SCRAM_SWAPS-1, go to FIXUP.
//  FIXUP (1 cycle):
//   - if working == target, rotate left by one over positions 0..len-1, applied once.
//   - busy <= 0, go to PLAY. busy is therefore high for SCRAM_SWAPS+1 cycles.
//  PLAY: a flipPls is valid only if indIn1 < len, indIn2 < len and indIn1 != indIn2.
//   - valid: swap the two letters at that edge, swapCount++ (saturating), go to COMPARE.
//   - invalid: no change, no count.
//  COMPARE (1 cycle; flipPls ignored):
//   - match: isCorrect <= 1, go to SOLVED.
//   - no match: go to PLAY.
//   isCorrect rises 2 edges after the sampled flipPls and is high for exactly 1 cycle.
//  SOLVED: word held; flipPls ignored; isCorrect back to 0. Leaves only on scramPls.
//  An all-identical word (e.g. "AAAA") still reaches PLAY. The first valid flip then yields isCorrect.
//  Compare covers all MAXLEN slots. Unused slots are 0 in both words, so they always match.
//  wordOut = working register, continuously driven (registered, no extra latency).
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with scramPls=1 -> isCorrect=0, busy=0, wordOut=0, swapCount=0.
//  2 Scramble: lettNum=0, wordIn="GAME" in slots 0..3, pulse scramPls
//    -> busy=1 for 17 cycles; wordOut is a permutation of G,A,M,E; slots 4..7 = 0;
//       wordOut != "GAME".
//  3 Solve: drive valid flips that restore "GAME"
//    -> isCorrect is a 1-cycle pulse 2 edges after the last flip; swapCount = number of flips;
//       a later flipPls does not change wordOut.
//  4 Invalid flips, len=4: indIn1=5 indIn2=0, then indIn1=indIn2=2, and a flip during COMPARE
//    -> wordOut unchanged, swapCount unchanged, no isCorrect.
//  5 Collisions: scramPls+flipPls in the same cycle in PLAY -> reload and rescramble, swapCount=0;
//    scramPls while busy=1 -> ignored, busy length unchanged.
//  6 Reset mid-scramble (rst=0 on the 5th busy cycle)
//    -> next edge: state IDLE, busy=0, wordOut=0; a subsequent scramPls works normally.
//    Also check lettNum=3 gives len=7 and that "AAAA" reaches PLAY.

Source files
------------

// File: rtl/word_scrambler_if.sv
// Controller-side bundle for the word scrambler: word load, scramble/flip requests
// and the working-word / status feedback.
interface word_scrambler_if #(
    parameter int unsigned MaxLen = 8,
    parameter int unsigned Lw     = 5
);
    logic [1:0]                lett_num;
    logic [MaxLen*Lw-1:0]      word_in;
    logic                      scram_pls;
    logic                      flip_pls;
    logic [$clog2(MaxLen)-1:0] ind_in1;
    logic [$clog2(MaxLen)-1:0] ind_in2;
    logic                      is_correct;
    logic                      busy;
    logic [MaxLen*Lw-1:0]      word_out;
    logic [6:0]                swap_count;

    modport master (
        output lett_num, word_in, scram_pls, flip_pls, ind_in1, ind_in2,
        input  is_correct, busy, word_out, swap_count
    );

    modport slave (
        input  lett_num, word_in, scram_pls, flip_pls, ind_in1, ind_in2,
        output is_correct, busy, word_out, swap_count
    );
endinterface

// File: rtl/word_scrambler.sv
// Letter-buffer datapath: loads a target word, scrambles it with a free-running LFSR,
// applies player swaps and pulses is_correct when the working word matches the target.
module word_scrambler #(
    parameter int unsigned MaxLen     = 8,
    parameter int unsigned Lw         = 5,
    parameter int unsigned ScramSwaps = 16,
    parameter logic [7:0]  LfsrSeed   = 8'hA5
) (
    input logic             clk,
    input logic             rst,
    word_scrambler_if.slave bus
);
    localparam int unsigned IdxW = $clog2(MaxLen);
    localparam int unsigned CntW = (ScramSwaps > 1) ? $clog2(ScramSwaps) : 1;

    typedef logic [Lw-1:0] letter_t;

    typedef enum logic [2:0] {
        StIdle,
        StScramble,
        StFixup,
        StPlay,
        StCompare,
        StSolved
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    letter_t         work_q   [MaxLen];
    letter_t         work_d   [MaxLen];
    letter_t         target_q [MaxLen];
    letter_t         target_d [MaxLen];
    logic [IdxW-1:0] len_q, len_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      swap_cnt_q, swap_cnt_d;
    logic            busy_q, busy_d;
    logic            is_correct_q, is_correct_d;

    logic [IdxW-1:0] len_new;
    logic [IdxW-1:0] raw_i, raw_j, scr_i, scr_j;
    logic            match;
    logic            flip_ok;
    logic            accept_scram;
    logic            lfsr_fb;
    logic [MaxLen*Lw-1:0] word_out_flat;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d  = (lfsr_q == 8'h00) ? LfsrSeed : {lfsr_q[6:0], lfsr_fb};

    assign len_new = IdxW'(bus.lett_num) + IdxW'(4);

    // A single conditional subtract suffices because len >= MaxLen/2
    assign raw_i = lfsr_q[IdxW-1:0];
    assign raw_j = lfsr_q[2*IdxW-1:IdxW];
    assign scr_i = (raw_i >= len_q) ? raw_i - len_q : raw_i;
    assign scr_j = (raw_j >= len_q) ? raw_j - len_q : raw_j;

    assign flip_ok = (bus.ind_in1 < len_q) && (bus.ind_in2 < len_q) &&
                     (bus.ind_in1 != bus.ind_in2);

    assign accept_scram = bus.scram_pls &&
                          (state_q == StIdle || state_q == StPlay || state_q == StSolved);

    always_comb begin
        match = 1'b1;
        for (int unsigned k = 0; k < MaxLen; k++) begin
            if (work_q[k] != target_q[k]) match = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        target_d     = target_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        swap_cnt_d   = swap_cnt_q;
        busy_d       = busy_q;
        is_correct_d = 1'b0;

        if (accept_scram) begin
            len_d = len_new;
            for (int unsigned k = 0; k < MaxLen; k++) begin
                target_d[k] = (IdxW'(k) < len_new) ? bus.word_in[k*Lw +: Lw] : '0;
                work_d[k]   = (IdxW'(k) < len_new) ? bus.word_in[k*Lw +: Lw] : '0;
            end
            swap_cnt_d = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = StScramble;
        end else begin
            case (state_q)
                StScramble: begin
                    work_d[scr_i] = work_q[scr_j];
                    work_d[scr_j] = work_q[scr_i];
                    cnt_d         = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(ScramSwaps - 1)) state_d = StFixup;
                end
                StFixup: begin
                    // Never hand the player an already-solved word
                    if (match) begin
                        for (int unsigned k = 0; k < MaxLen - 1; k++) begin
                            if (IdxW'(k) < len_q - IdxW'(1)) work_d[k] = work_q[k+1];
                        end
                        work_d[len_q - IdxW'(1)] = work_q[0];
                    end
                    busy_d  = 1'b0;
                    state_d = StPlay;
                end
                StPlay: begin
                    if (bus.flip_pls && flip_ok) begin
                        work_d[bus.ind_in1] = work_q[bus.ind_in2];
                        work_d[bus.ind_in2] = work_q[bus.ind_in1];
                        swap_cnt_d = (swap_cnt_q == 7'h7f) ? swap_cnt_q : swap_cnt_q + 7'd1;
                        state_d    = StCompare;
                    end
                end
                StCompare: begin
                    if (match) begin
                        is_correct_d = 1'b1;
                        state_d      = StSolved;
                    end else begin
                        state_d = StPlay;
                    end
                end
                StIdle, StSolved: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            lfsr_q       <= LfsrSeed;
            len_q        <= '0;
            cnt_q        <= '0;
            swap_cnt_q   <= '0;
            busy_q       <= 1'b0;
            is_correct_q <= 1'b0;
            for (int unsigned k = 0; k < MaxLen; k++) begin
                work_q[k]   <= '0;
                target_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            swap_cnt_q   <= swap_cnt_d;
            busy_q       <= busy_d;
            is_correct_q <= is_correct_d;
            for (int unsigned k = 0; k < MaxLen; k++) begin
                work_q[k]   <= work_d[k];
                target_q[k] <= target_d[k];
            end
        end
    end

    always_comb begin
        word_out_flat = '0;
        for (int unsigned k = 0; k < MaxLen; k++) begin
            word_out_flat[k*Lw +: Lw] = work_q[k];
        end
    end

    assign bus.word_out   = word_out_flat;
    assign bus.busy       = busy_q;
    assign bus.is_correct = is_correct_q;
    assign bus.swap_count = swap_cnt_q;
endmodule

// File: tb/tb_word_scrambler.sv
// Directed bench for word_scrambler: table of word loads and invalid flips, plus
// hand-written collision, solve and mid-scramble reset sequences.
module tb_word_scrambler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_scrambler_if #(.MaxLen(8), .Lw(5)) bus ();

    word_scrambler #(
        .MaxLen    (8),
        .Lw        (5),
        .ScramSwaps(16),
        .LfsrSeed  (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  lett;
        logic [39:0] word;
        logic [39:0] masked;
        bit          distinct;
    } load_vec_t;

    typedef struct {
        logic [2:0] i1;
        logic [2:0] i2;
    } bad_flip_t;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] model;
    int          exp_cnt;
    load_vec_t   lv[6];
    bad_flip_t   bf[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mkw(input int l0, input int l1, input int l2, input int l3,
                                        input int l4, input int l5, input int l6, input int l7);
        return {5'(l7), 5'(l6), 5'(l5), 5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    function automatic logic [4:0] slot(input logic [39:0] w, input int k);
        return w[k*5 +: 5];
    endfunction

    function automatic logic [39:0] swapw(input logic [39:0] w, input int p, input int q);
        logic [39:0] r;
        r = w;
        r[p*5 +: 5] = w[q*5 +: 5];
        r[q*5 +: 5] = w[p*5 +: 5];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a word; optionally collide with a flip, re-pulse scram mid-busy, or reset mid-busy
    task automatic do_load(input load_vec_t v, input bit with_flip, input int inject_at,
                           input int abort_at);
        int n;
        bus.lett_num  = v.lett;
        bus.word_in   = v.word;
        bus.scram_pls = 1'b1;
        if (with_flip) begin
            bus.flip_pls = 1'b1;
            bus.ind_in1  = 3'd0;
            bus.ind_in2  = 3'd1;
        end
        step();
        bus.scram_pls = 1'b0;
        bus.flip_pls  = 1'b0;
        check("load_busy", 64'(bus.busy), 64'd1);
        check("load_word", 64'(bus.word_out), 64'(v.masked));
        check("load_count", 64'(bus.swap_count), 64'd0);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == abort_at) begin
                rst = 1'b0;
                step();
                check("abort_busy", 64'(bus.busy), 64'd0);
                check("abort_word", 64'(bus.word_out), 64'd0);
                check("abort_count", 64'(bus.swap_count), 64'd0);
                rst = 1'b1;
                return;
            end
            if (n == inject_at) begin
                bus.scram_pls = 1'b1;
                bus.flip_pls  = 1'b1;
                bus.ind_in1   = 3'd0;
                bus.ind_in2   = 3'd1;
                bus.word_in   = ~v.word;
            end
            step();
            bus.scram_pls = 1'b0;
            bus.flip_pls  = 1'b0;
            bus.word_in   = v.word;
        end
        check("busy_cycles", 64'(n), 64'd17);
    endtask

    task automatic check_perm(input load_vec_t v);
        int          h[32];
        bit          ok;
        int          len;
        logic [39:0] w;
        ok  = 1'b1;
        len = int'(v.lett) + 4;
        w   = bus.word_out;
        for (int k = 0; k < 32; k++) h[k] = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < len) begin
                h[slot(w, k)]++;
                h[slot(v.masked, k)]--;
            end else if (slot(w, k) != 5'd0) begin
                ok = 1'b0;
            end
        end
        for (int k = 0; k < 32; k++) if (h[k] != 0) ok = 1'b0;
        check("perm", 64'(ok), 64'd1);
        check("in_play_not_busy", 64'(bus.busy), 64'd0);
        if (v.distinct) check("scrambled", 64'(w != v.masked), 64'd1);
    endtask

    // Flip held for two edges: the second lands in the compare cycle and must be ignored
    task automatic do_flip(input int p, input int q, input logic [39:0] tgt);
        bit solved;
        model = swapw(model, p, q);
        exp_cnt++;
        solved = (model == tgt);
        bus.ind_in1  = 3'(p);
        bus.ind_in2  = 3'(q);
        bus.flip_pls = 1'b1;
        step();
        check("flip_word", 64'(bus.word_out), 64'(model));
        check("flip_count", 64'(bus.swap_count), 64'(exp_cnt));
        check("flip_early", 64'(bus.is_correct), 64'd0);
        step();
        bus.flip_pls = 1'b0;
        check("cmp_word", 64'(bus.word_out), 64'(model));
        check("is_correct", 64'(bus.is_correct), 64'(solved));
        if (solved) begin
            step();
            check("pulse_end", 64'(bus.is_correct), 64'd0);
        end
    endtask

    task automatic do_solve(input load_vec_t v);
        int          len;
        int          ps[$];
        int          qs[$];
        logic [39:0] m;
        len     = int'(v.lett) + 4;
        model   = bus.word_out;
        m       = model;
        exp_cnt = 0;
        for (int p = 0; p < len; p++) begin
            if (slot(m, p) != slot(v.masked, p)) begin
                for (int q = p + 1; q < len; q++) begin
                    if (slot(m, q) == slot(v.masked, p)) begin
                        ps.push_back(p);
                        qs.push_back(q);
                        m = swapw(m, p, q);
                        break;
                    end
                end
            end
        end
        if (ps.size() == 0) begin
            ps.push_back(0);
            qs.push_back(1);
        end
        for (int i = 0; i < ps.size(); i++) do_flip(ps[i], qs[i], v.masked);
        check("solved_word", 64'(bus.word_out), 64'(v.masked));
        check("solved_count", 64'(bus.swap_count), 64'(ps.size()));
        bus.ind_in1  = 3'd0;
        bus.ind_in2  = 3'd2;
        bus.flip_pls = 1'b1;
        step();
        bus.flip_pls = 1'b0;
        step();
        check("solved_hold_word", 64'(bus.word_out), 64'(v.masked));
        check("solved_hold_count", 64'(bus.swap_count), 64'(exp_cnt));
        check("solved_hold_correct", 64'(bus.is_correct), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] saved;
        bit          picked;

        // Letter codes: A=1 ... Z=26
        lv[0] = '{2'd0, mkw(7, 1, 13, 5, 0, 0, 0, 0), mkw(7, 1, 13, 5, 0, 0, 0, 0), 1'b1};
        lv[1] = '{2'd0, mkw(7, 1, 13, 5, 26, 25, 24, 23), mkw(7, 1, 13, 5, 0, 0, 0, 0), 1'b1};
        lv[2] = '{2'd3, mkw(4, 18, 1, 23, 9, 14, 7, 31), mkw(4, 18, 1, 23, 9, 14, 7, 0), 1'b1};
        lv[3] = '{2'd1, mkw(13, 1, 14, 7, 15, 3, 3, 3), mkw(13, 1, 14, 7, 15, 0, 0, 0), 1'b1};
        lv[4] = '{2'd0, mkw(1, 1, 1, 1, 9, 9, 9, 9), mkw(1, 1, 1, 1, 0, 0, 0, 0), 1'b0};
        lv[5] = '{2'd2, mkw(16, 12, 1, 14, 5, 20, 2, 2), mkw(16, 12, 1, 14, 5, 20, 0, 0), 1'b1};
        bf[0] = '{3'd5, 3'd0};
        bf[1] = '{3'd2, 3'd2};
        bf[2] = '{3'd0, 3'd4};
        bf[3] = '{3'd7, 3'd3};

        bus.lett_num  = 2'd0;
        bus.word_in   = lv[0].word;
        bus.scram_pls = 1'b1;
        bus.flip_pls  = 1'b0;
        bus.ind_in1   = 3'd0;
        bus.ind_in2   = 3'd0;
        rst           = 1'b0;
        step();
        step();
        check("rst_correct", 64'(bus.is_correct), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_word", 64'(bus.word_out), 64'd0);
        check("rst_count", 64'(bus.swap_count), 64'd0);
        bus.scram_pls = 1'b0;
        rst           = 1'b1;
        step();

        do_load(lv[0], 1'b0, 0, 0);
        check_perm(lv[0]);

        for (int i = 0; i < 4; i++) begin
            saved        = bus.word_out;
            bus.ind_in1  = bf[i].i1;
            bus.ind_in2  = bf[i].i2;
            bus.flip_pls = 1'b1;
            step();
            bus.flip_pls = 1'b0;
            check("bad_flip_word", 64'(bus.word_out), 64'(saved));
            check("bad_flip_count", 64'(bus.swap_count), 64'd0);
            step();
            check("bad_flip_correct", 64'(bus.is_correct), 64'd0);
        end

        // One valid flip that leaves the puzzle unsolved, so the collision happens in play
        model   = bus.word_out;
        exp_cnt = 0;
        picked  = 1'b0;
        for (int p = 0; p < 4 && !picked; p++) begin
            for (int q = p + 1; q < 4 && !picked; q++) begin
                if (swapw(model, p, q) != lv[0].masked) begin
                    picked = 1'b1;
                    do_flip(p, q, lv[0].masked);
                end
            end
        end

        do_load(lv[1], 1'b1, 3, 0);
        check_perm(lv[1]);
        do_solve(lv[1]);

        for (int i = 2; i < 6; i++) begin
            do_load(lv[i], 1'b0, 0, 0);
            check_perm(lv[i]);
            do_solve(lv[i]);
        end

        do_load(lv[0], 1'b0, 0, 5);
        do_load(lv[2], 1'b0, 0, 0);
        check_perm(lv[2]);
        do_solve(lv[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
